// File: rtl/ct_ebiuif_snoop_ctrl_if.sv
// ---------------------------------------------------------------------------
// ct_ebiuif_snoop_ctrl_if
// Bundles every handshake/bus signal of the EBIU-side snoop controller:
//   - AC channel  : EBIU -> controller snoop requests (valid/grant + fields)
//   - CR channel  : controller -> EBIU snoop response (valid/grant + resp)
//   - CD channel  : controller -> EBIU 128-bit data beats (valid/grant/last)
//   - snoop unit  : controller -> CIU snoop request, response pulse, data beats
//   - status      : sticky snoop timeout flag
// Modports:
//   slave  : the view used by ct_ebiuif_snoop_ctrl
//   master : the view used by the surrounding EBIU / snoop unit (or a bench)
// Parameter ADDRW defaults to `PA_WIDTH (40 when not supplied by the build).
// ---------------------------------------------------------------------------
`ifndef PA_WIDTH
`define PA_WIDTH 40
`endif

interface ct_ebiuif_snoop_ctrl_if #(
    parameter int ADDRW = `PA_WIDTH
);
    // AC channel
    logic             ebiu_ebiuif_acvalid;
    logic [ADDRW-1:0] ebiu_ebiuif_acaddr;
    logic [4:0]       ebiu_ebiuif_acid;
    logic [2:0]       ebiu_ebiuif_acprot;
    logic [3:0]       ebiu_ebiuif_acsnoop;
    logic             ebiu_snoop_channel_no_op;
    logic             ebiuif_ebiu_ac_grant;
    // CR channel
    logic             ebiuif_ebiu_crvalid;
    logic [4:0]       ebiuif_ebiu_crresp;
    logic             ebiu_ebiuif_cr_grant;
    // CD channel
    logic             ebiuif_ebiu_cdvalid;
    logic [127:0]     ebiuif_ebiu_cddata;
    logic             ebiuif_ebiu_cdlast;
    logic             ebiu_ebiuif_cd_grant;
    // Snoop unit side
    logic             ebiuif_snp_req_vld;
    logic [ADDRW-1:0] ebiuif_snp_req_addr;
    logic [4:0]       ebiuif_snp_req_id;
    logic [2:0]       ebiuif_snp_req_prot;
    logic [3:0]       ebiuif_snp_req_snoop;
    logic             snp_ebiuif_req_rdy;
    logic             snp_ebiuif_resp_vld;
    logic [4:0]       snp_ebiuif_resp;
    logic             snp_ebiuif_data_vld;
    logic [127:0]     snp_ebiuif_data;
    logic             ebiuif_snp_data_rdy;
    // Status
    logic             ebiuif_snp_timeout_err;

    modport slave (
        input  ebiu_ebiuif_acvalid, ebiu_ebiuif_acaddr, ebiu_ebiuif_acid,
               ebiu_ebiuif_acprot, ebiu_ebiuif_acsnoop, ebiu_snoop_channel_no_op,
               ebiu_ebiuif_cr_grant, ebiu_ebiuif_cd_grant,
               snp_ebiuif_req_rdy, snp_ebiuif_resp_vld, snp_ebiuif_resp,
               snp_ebiuif_data_vld, snp_ebiuif_data,
        output ebiuif_ebiu_ac_grant, ebiuif_ebiu_crvalid, ebiuif_ebiu_crresp,
               ebiuif_ebiu_cdvalid, ebiuif_ebiu_cddata, ebiuif_ebiu_cdlast,
               ebiuif_snp_req_vld, ebiuif_snp_req_addr, ebiuif_snp_req_id,
               ebiuif_snp_req_prot, ebiuif_snp_req_snoop, ebiuif_snp_data_rdy,
               ebiuif_snp_timeout_err
    );

    modport master (
        output ebiu_ebiuif_acvalid, ebiu_ebiuif_acaddr, ebiu_ebiuif_acid,
               ebiu_ebiuif_acprot, ebiu_ebiuif_acsnoop, ebiu_snoop_channel_no_op,
               ebiu_ebiuif_cr_grant, ebiu_ebiuif_cd_grant,
               snp_ebiuif_req_rdy, snp_ebiuif_resp_vld, snp_ebiuif_resp,
               snp_ebiuif_data_vld, snp_ebiuif_data,
        input  ebiuif_ebiu_ac_grant, ebiuif_ebiu_crvalid, ebiuif_ebiu_crresp,
               ebiuif_ebiu_cdvalid, ebiuif_ebiu_cddata, ebiuif_ebiu_cdlast,
               ebiuif_snp_req_vld, ebiuif_snp_req_addr, ebiuif_snp_req_id,
               ebiuif_snp_req_prot, ebiuif_snp_req_snoop, ebiuif_snp_data_rdy,
               ebiuif_snp_timeout_err
    );
endinterface

// File: rtl/ct_ebiuif_snoop_ctrl.sv
// ---------------------------------------------------------------------------
// ct_ebiuif_snoop_ctrl
// CIU-side snoop controller behind the EBIU snoop channel. ACE snoop requests
// (AC) are buffered in a small FIFO and issued one at a time to the CIU snoop
// unit. The snoop response is returned on CR and, when DataTransfer is set,
// the 64-byte line is returned as four 128-bit CD beats.
// Ports:
//   forever_cpuclk : clock (single domain)
//   cpurst_b       : asynchronous active-low reset
//   bus            : ct_ebiuif_snoop_ctrl_if.slave (AC/CR/CD + snoop unit)
// Parameters:
//   DEPTH  : AC FIFO entries (power of two, 2..4)
//   ADDRW  : physical address width
//   TO_CNT : response timeout in cycles (only with the macro below)
// Optional feature macro: EBIUIF_SNP_TIMEOUT_EN
//   defined   -> WRSP timeout forces an Error response and sets a sticky flag
//   undefined -> WRSP waits indefinitely, timeout flag tied low
// ---------------------------------------------------------------------------
`ifndef PA_WIDTH
`define PA_WIDTH 40
`endif

module ct_ebiuif_snoop_ctrl #(
    parameter int DEPTH  = 2,
    parameter int ADDRW  = `PA_WIDTH,
    parameter int TO_CNT = 1024
) (
    input  logic                   forever_cpuclk,
    input  logic                   cpurst_b,
    ct_ebiuif_snoop_ctrl_if.slave  bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, WRSP, XFER} state_t;

    state_t           r_state;
    state_t           w_nextState;

    logic [ADDRW-1:0] r_acAddr  [DEPTH];
    logic [4:0]       r_acId    [DEPTH];
    logic [2:0]       r_acProt  [DEPTH];
    logic [3:0]       r_acSnoop [DEPTH];
    logic [PW-1:0]    r_wrPtr;
    logic [PW-1:0]    r_rdPtr;
    logic [CW-1:0]    r_count;
    logic             r_grantEn;

    logic             r_crValid;
    logic [4:0]       r_crResp;
    logic             r_cdValid;
    logic [127:0]     r_cdData;
    logic             r_cdLast;
    logic [2:0]       r_beatsRecv;
    logic [2:0]       r_beatsSent;

    logic             w_full;
    logic             w_empty;
    logic             w_acGrant;
    logic             w_push;
    logic             w_pop;
    logic             w_reqVld;
    logic             w_timeout;
    logic             w_respTake;
    logic [4:0]       w_respCode;
    logic             w_beatRdy;
    logic             w_beatTake;
    logic             w_cdSend;
    logic             w_crDone;
    logic             w_cdDone;

    // Grant is held low while in reset and released one cycle afterwards.
    assign w_full    = (r_count == FULL_CNT);
    assign w_empty   = (r_count == '0);
    assign w_acGrant = r_grantEn & ~w_full & ~bus.ebiu_snoop_channel_no_op;
    assign w_push    = bus.ebiu_ebiuif_acvalid & w_acGrant;
    assign w_pop     = (r_state == REQ) & bus.snp_ebiuif_req_rdy;

    // Grant enable, FIFO pointers and occupancy.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_grantEn <= 1'b0;
            r_wrPtr   <= '0;
            r_rdPtr   <= '0;
            r_count   <= '0;
        end else begin
            r_grantEn <= 1'b1;
            if (w_push) r_wrPtr <= r_wrPtr + PW'(1);
            if (w_pop)  r_rdPtr <= r_rdPtr + PW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO payload storage; contents are only meaningful under the pointers.
    always_ff @(posedge forever_cpuclk) begin
        if (w_push) begin
            r_acAddr[r_wrPtr]  <= bus.ebiu_ebiuif_acaddr;
            r_acId[r_wrPtr]    <= bus.ebiu_ebiuif_acid;
            r_acProt[r_wrPtr]  <= bus.ebiu_ebiuif_acprot;
            r_acSnoop[r_wrPtr] <= bus.ebiu_ebiuif_acsnoop;
        end
    end

`ifdef EBIUIF_SNP_TIMEOUT_EN
    localparam int TOW = (TO_CNT > 2) ? $clog2(TO_CNT) : 1;
    localparam logic [TOW-1:0] TO_LAST = TOW'(TO_CNT - 1);

    logic [TOW-1:0] r_toCnt;
    logic           r_timeoutErr;

    // Wait counter restarts every time WRSP is entered.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_toCnt <= '0;
        end else if (r_state != WRSP) begin
            r_toCnt <= '0;
        end else if (r_toCnt != TO_LAST) begin
            r_toCnt <= r_toCnt + TOW'(1);
        end
    end

    // A real response in the expiry cycle takes priority over the timeout.
    assign w_timeout = (r_state == WRSP) & (r_toCnt == TO_LAST) & ~bus.snp_ebiuif_resp_vld;

    // Sticky until reset.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_timeoutErr <= 1'b0;
        end else if (w_timeout) begin
            r_timeoutErr <= 1'b1;
        end
    end

    assign bus.ebiuif_snp_timeout_err = r_timeoutErr;
`else
    assign w_timeout                  = 1'b0;
    assign bus.ebiuif_snp_timeout_err = 1'b0;
`endif

    assign w_respTake = (r_state == WRSP) & (bus.snp_ebiuif_resp_vld | w_timeout);
    assign w_respCode = bus.snp_ebiuif_resp_vld ? bus.snp_ebiuif_resp : 5'b00010;

    // Holding register refills in the same cycle it drains, so a granted
    // stream sustains one beat per cycle.
    assign w_cdSend   = r_cdValid & bus.ebiu_ebiuif_cd_grant;
    assign w_beatRdy  = (r_state == XFER) & r_crResp[0] & (r_beatsRecv < 3'd4) &
                        (~r_cdValid | bus.ebiu_ebiuif_cd_grant);
    assign w_beatTake = w_beatRdy & bus.snp_ebiuif_data_vld;

    // Each leg is done either already or by a grant in this cycle.
    assign w_crDone = ~r_crValid | bus.ebiu_ebiuif_cr_grant;
    assign w_cdDone = ~r_crResp[0] | (r_beatsSent == 3'd4) |
                      ((r_beatsSent == 3'd3) & w_cdSend);

    // State register.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and snoop request valid.
    always_comb begin
        w_nextState = r_state;
        w_reqVld    = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) w_nextState = REQ;
            end
            REQ: begin
                w_reqVld = 1'b1;
                if (bus.snp_ebiuif_req_rdy) w_nextState = WRSP;
            end
            WRSP: begin
                if (w_respTake) w_nextState = XFER;
            end
            XFER: begin
                if (w_crDone && w_cdDone) w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    // CR register, CD holding register and beat counters.
    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            r_crValid   <= 1'b0;
            r_crResp    <= 5'b0;
            r_cdValid   <= 1'b0;
            r_cdData    <= 128'b0;
            r_cdLast    <= 1'b0;
            r_beatsRecv <= 3'd0;
            r_beatsSent <= 3'd0;
        end else begin
            if (w_respTake) begin
                r_crValid <= 1'b1;
                r_crResp  <= w_respCode;
            end else if (r_crValid && bus.ebiu_ebiuif_cr_grant) begin
                r_crValid <= 1'b0;
            end

            if (w_beatTake) begin
                r_cdValid <= 1'b1;
                r_cdData  <= bus.snp_ebiuif_data;
                r_cdLast  <= (r_beatsRecv == 3'd3);
            end else if (w_cdSend) begin
                r_cdValid <= 1'b0;
                r_cdLast  <= 1'b0;
            end

            if (w_respTake) begin
                r_beatsRecv <= 3'd0;
                r_beatsSent <= 3'd0;
            end else begin
                if (w_beatTake) r_beatsRecv <= r_beatsRecv + 3'd1;
                if (w_cdSend)   r_beatsSent <= r_beatsSent + 3'd1;
            end
        end
    end

    assign bus.ebiuif_ebiu_ac_grant = w_acGrant;
    assign bus.ebiuif_ebiu_crvalid  = r_crValid;
    assign bus.ebiuif_ebiu_crresp   = r_crResp;
    assign bus.ebiuif_ebiu_cdvalid  = r_cdValid;
    assign bus.ebiuif_ebiu_cddata   = r_cdData;
    assign bus.ebiuif_ebiu_cdlast   = r_cdLast;
    assign bus.ebiuif_snp_data_rdy  = w_beatRdy;

    // Request fields are zeroed whenever no request is being offered.
    assign bus.ebiuif_snp_req_vld   = w_reqVld;
    assign bus.ebiuif_snp_req_addr  = w_reqVld ? r_acAddr[r_rdPtr]  : '0;
    assign bus.ebiuif_snp_req_id    = w_reqVld ? r_acId[r_rdPtr]    : 5'b0;
    assign bus.ebiuif_snp_req_prot  = w_reqVld ? r_acProt[r_rdPtr]  : 3'b0;
    assign bus.ebiuif_snp_req_snoop = w_reqVld ? r_acSnoop[r_rdPtr] : 4'b0;

endmodule

// File: tb/tb_ct_ebiuif_snoop_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ct_ebiuif_snoop_ctrl
// Directed bench for ct_ebiuif_snoop_ctrl. Stimulus tasks push the expected
// snoop request, CR response and CD beats into queues; a negedge monitor pops
// and compares whenever the DUT completes a handshake.
// ---------------------------------------------------------------------------
module tb_ct_ebiuif_snoop_ctrl;
    localparam int ADDRW  = 40;
    localparam int DEPTH  = 2;
    localparam int TO_CNT = 32;

    typedef struct packed {
        logic [ADDRW-1:0] addr;
        logic [4:0]       id;
        logic [2:0]       prot;
        logic [3:0]       snoop;
    } req_t;

    logic clk;
    logic cpurst_b;
    int   checks = 0;
    int   errors = 0;

    req_t         reqQ[$];
    logic [4:0]   crQ[$];
    logic [128:0] cdQ[$];

    ct_ebiuif_snoop_ctrl_if #(.ADDRW(ADDRW)) bus ();

    ct_ebiuif_snoop_ctrl #(
        .DEPTH (DEPTH),
        .ADDRW (ADDRW),
        .TO_CNT(TO_CNT)
    ) dut (
        .forever_cpuclk(clk),
        .cpurst_b      (cpurst_b),
        .bus           (bus)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop if something hangs despite the bounded waits.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not complete, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [135:0] act, input logic [135:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic reportTimeout(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: wait bound expired (got none, expected handshake) at %0t", name, $time);
    endtask

    function automatic logic [127:0] beatVal(input logic [31:0] seed, input int idx);
        logic [31:0] w;
        w = seed + 32'(idx);
        return {w, w, w, w};
    endfunction

    // Scoreboard monitor: compares on every completed DUT handshake.
    always @(negedge clk) begin
        if (cpurst_b) begin
            if (bus.ebiuif_snp_req_vld) begin
                checkOutput("reqExclusive", 136'(bus.ebiuif_ebiu_crvalid | bus.ebiuif_ebiu_cdvalid), 136'(0));
                if (bus.snp_ebiuif_req_rdy) begin
                    if (reqQ.size() == 0) begin
                        checkOutput("reqUnexpected", 136'({bus.ebiuif_snp_req_addr, bus.ebiuif_snp_req_id,
                                    bus.ebiuif_snp_req_prot, bus.ebiuif_snp_req_snoop}), 136'(0));
                    end else begin
                        checkOutput("reqFields", 136'({bus.ebiuif_snp_req_addr, bus.ebiuif_snp_req_id,
                                    bus.ebiuif_snp_req_prot, bus.ebiuif_snp_req_snoop}), 136'(reqQ.pop_front()));
                    end
                end
            end
            if (bus.ebiuif_ebiu_crvalid && bus.ebiu_ebiuif_cr_grant) begin
                if (crQ.size() == 0) checkOutput("crUnexpected", 136'(bus.ebiuif_ebiu_crvalid), 136'(0));
                else checkOutput("crResp", 136'(bus.ebiuif_ebiu_crresp), 136'(crQ.pop_front()));
            end
            if (bus.ebiuif_ebiu_cdvalid && bus.ebiu_ebiuif_cd_grant) begin
                if (cdQ.size() == 0) checkOutput("cdUnexpected", 136'(bus.ebiuif_ebiu_cdvalid), 136'(0));
                else checkOutput("cdBeat", 136'({bus.ebiuif_ebiu_cdlast, bus.ebiuif_ebiu_cddata}), 136'(cdQ.pop_front()));
            end
        end
    end

    // Present one AC request and hold it until granted.
    task automatic applyStimulus(input logic [ADDRW-1:0] addr, input logic [4:0] id,
                                 input logic [2:0] prot, input logic [3:0] snoop);
        int n;
        req_t r;
        r.addr = addr; r.id = id; r.prot = prot; r.snoop = snoop;
        reqQ.push_back(r);
        @(posedge clk); #1;
        bus.ebiu_ebiuif_acaddr  = addr;
        bus.ebiu_ebiuif_acid    = id;
        bus.ebiu_ebiuif_acprot  = prot;
        bus.ebiu_ebiuif_acsnoop = snoop;
        bus.ebiu_ebiuif_acvalid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.ebiuif_ebiu_ac_grant && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.ebiuif_ebiu_ac_grant) reportTimeout("acGrantWait");
        @(posedge clk); #1;
        bus.ebiu_ebiuif_acvalid = 1'b0;
    endtask

    // Snoop unit model: accept one request, respond after 'delay' cycles,
    // then supply four beats if DataTransfer is set.
    task automatic serveSnoop(input logic [4:0] resp, input int delay, input logic [31:0] seed);
        int n;
        crQ.push_back(resp);
        if (resp[0]) begin
            for (int i = 0; i < 4; i++) cdQ.push_back({(i == 3), beatVal(seed, i)});
        end
        @(posedge clk); #1;
        bus.snp_ebiuif_req_rdy = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.ebiuif_snp_req_vld && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.ebiuif_snp_req_vld) reportTimeout("reqWait");
        @(posedge clk); #1;
        bus.snp_ebiuif_req_rdy = 1'b0;
        if (delay > 0) begin
            repeat (delay) @(posedge clk);
            #1;
        end
        bus.snp_ebiuif_resp_vld = 1'b1;
        bus.snp_ebiuif_resp     = resp;
        @(posedge clk); #1;
        bus.snp_ebiuif_resp_vld = 1'b0;
        @(negedge clk);
        checkOutput("crLatency", 136'(bus.ebiuif_ebiu_crvalid), 136'(1));
        if (resp[0]) begin
            for (int i = 0; i < 4; i++) begin
                @(posedge clk); #1;
                bus.snp_ebiuif_data_vld = 1'b1;
                bus.snp_ebiuif_data     = beatVal(seed, i);
                n = 0;
                @(negedge clk);
                while (!bus.ebiuif_snp_data_rdy && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                if (!bus.ebiuif_snp_data_rdy) reportTimeout("beatWait");
            end
            @(posedge clk); #1;
            bus.snp_ebiuif_data_vld = 1'b0;
        end
    endtask

    initial begin
        int n;
        cpurst_b                     = 1'b0;
        bus.ebiu_ebiuif_acvalid      = 1'b0;
        bus.ebiu_ebiuif_acaddr       = '0;
        bus.ebiu_ebiuif_acid         = '0;
        bus.ebiu_ebiuif_acprot       = '0;
        bus.ebiu_ebiuif_acsnoop      = '0;
        bus.ebiu_snoop_channel_no_op = 1'b0;
        bus.ebiu_ebiuif_cr_grant     = 1'b1;
        bus.ebiu_ebiuif_cd_grant     = 1'b1;
        bus.snp_ebiuif_req_rdy       = 1'b0;
        bus.snp_ebiuif_resp_vld      = 1'b0;
        bus.snp_ebiuif_resp          = '0;
        bus.snp_ebiuif_data_vld      = 1'b0;
        bus.snp_ebiuif_data          = '0;

        // Reset values.
        repeat (3) @(negedge clk);
        checkOutput("rstAcGrant",   136'(bus.ebiuif_ebiu_ac_grant),   136'(0));
        checkOutput("rstCrValid",   136'(bus.ebiuif_ebiu_crvalid),    136'(0));
        checkOutput("rstCrResp",    136'(bus.ebiuif_ebiu_crresp),     136'(0));
        checkOutput("rstCdValid",   136'(bus.ebiuif_ebiu_cdvalid),    136'(0));
        checkOutput("rstCdData",    136'(bus.ebiuif_ebiu_cddata),     136'(0));
        checkOutput("rstCdLast",    136'(bus.ebiuif_ebiu_cdlast),     136'(0));
        checkOutput("rstReqVld",    136'(bus.ebiuif_snp_req_vld),     136'(0));
        checkOutput("rstDataRdy",   136'(bus.ebiuif_snp_data_rdy),    136'(0));
        checkOutput("rstTimeoutErr",136'(bus.ebiuif_snp_timeout_err), 136'(0));
        @(posedge clk); #1;
        cpurst_b = 1'b1;
        repeat (2) @(negedge clk);
        checkOutput("postRstAcGrant", 136'(bus.ebiuif_ebiu_ac_grant), 136'(1));

        // Single snoop, miss; request appears two cycles after the push.
        $display("[TB] single snoop miss");
        applyStimulus(40'h10_0000_0040, 5'd3, 3'd2, 4'h1);
        @(negedge clk);
        checkOutput("reqLatN1", 136'(bus.ebiuif_snp_req_vld), 136'(0));
        @(negedge clk);
        checkOutput("reqLatN2", 136'(bus.ebiuif_snp_req_vld), 136'(1));
        serveSnoop(5'b00000, 2, 32'h0);
        repeat (3) @(negedge clk);
        checkOutput("missIdleReq", 136'(bus.ebiuif_snp_req_vld), 136'(0));
        checkOutput("missNoCd",    136'(bus.ebiuif_ebiu_cdvalid), 136'(0));

        // Dirty hit with a second snoop queued behind it.
        $display("[TB] dirty hit");
        applyStimulus(40'h00_1234_5680, 5'd7, 3'd0, 4'h7);
        applyStimulus(40'h00_0000_1000, 5'd9, 3'd1, 4'h0);
        serveSnoop(5'b00101, 1, 32'hA000_0000);
        serveSnoop(5'b00000, 0, 32'h0);

        // Backpressure on CD while D2 is held.
        $display("[TB] cd backpressure");
        applyStimulus(40'h0F_FFFF_FFC0, 5'd31, 3'd7, 4'hF);
        fork
            serveSnoop(5'b10001, 3, 32'hB000_0010);
            begin
                n = 0;
                @(negedge clk);
                while (!(bus.ebiuif_ebiu_cdvalid && bus.ebiuif_ebiu_cddata == beatVal(32'hB000_0010, 1)) && n < 300) begin
                    @(negedge clk);
                    n++;
                end
                if (n >= 300) reportTimeout("stallStart");
                @(posedge clk); #1;
                bus.ebiu_ebiuif_cd_grant = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    checkOutput("stallCdValid", 136'(bus.ebiuif_ebiu_cdvalid), 136'(1));
                    checkOutput("stallCdData",  136'(bus.ebiuif_ebiu_cddata), 136'(beatVal(32'hB000_0010, 2)));
                    checkOutput("stallDataRdy", 136'(bus.ebiuif_snp_data_rdy), 136'(0));
                end
                @(posedge clk); #1;
                bus.ebiu_ebiuif_cd_grant = 1'b1;
            end
        join

        // FIFO full: two pushes fill it, the third waits for a pop.
        $display("[TB] fifo full");
        applyStimulus(40'h01_0000_0000, 5'd1, 3'd0, 4'h2);
        applyStimulus(40'h02_0000_0000, 5'd2, 3'd0, 4'h3);
        @(negedge clk);
        checkOutput("fullAcGrant", 136'(bus.ebiuif_ebiu_ac_grant), 136'(0));
        fork
            applyStimulus(40'h03_0000_0000, 5'd4, 3'd0, 4'h4);
            begin
                serveSnoop(5'b01000, 1, 32'h0);
                serveSnoop(5'b00000, 1, 32'h0);
                serveSnoop(5'b00000, 1, 32'h0);
            end
        join

        // no_op while a snoop waits for its response.
        $display("[TB] no_op during WRSP");
        applyStimulus(40'h04_0000_0040, 5'd5, 3'd3, 4'h8);
        fork
            serveSnoop(5'b01000, 8, 32'h0);
            begin
                n = 0;
                @(negedge clk);
                while (!(bus.ebiuif_snp_req_vld && bus.snp_ebiuif_req_rdy) && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                if (n >= 200) reportTimeout("noOpStart");
                @(posedge clk); #1;
                bus.ebiu_snoop_channel_no_op = 1'b1;
                @(negedge clk);
                checkOutput("noOpAcGrant", 136'(bus.ebiuif_ebiu_ac_grant), 136'(0));
            end
        join
        @(posedge clk); #1;
        bus.ebiu_snoop_channel_no_op = 1'b0;
        @(negedge clk);
        checkOutput("noOpRelease", 136'(bus.ebiuif_ebiu_ac_grant), 136'(1));

`ifdef EBIUIF_SNP_TIMEOUT_EN
        // No response: Error response, no data, sticky flag.
        $display("[TB] snoop timeout");
        applyStimulus(40'h05_0000_0080, 5'd6, 3'd0, 4'h9);
        crQ.push_back(5'b00010);
        @(posedge clk); #1;
        bus.snp_ebiuif_req_rdy = 1'b1;
        n = 0;
        @(negedge clk);
        while (!bus.ebiuif_snp_req_vld && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.ebiuif_snp_req_vld) reportTimeout("toReqWait");
        @(posedge clk); #1;
        bus.snp_ebiuif_req_rdy = 1'b0;
        n = 0;
        @(negedge clk);
        while (!bus.ebiuif_ebiu_crvalid && n < TO_CNT + 10) begin
            @(negedge clk);
            n++;
        end
        if (!bus.ebiuif_ebiu_crvalid) reportTimeout("toCrWait");
        checkOutput("toErrSet", 136'(bus.ebiuif_snp_timeout_err), 136'(1));
        repeat (5) @(negedge clk);
        checkOutput("toErrSticky", 136'(bus.ebiuif_snp_timeout_err), 136'(1));
        checkOutput("toNoCd",      136'(bus.ebiuif_ebiu_cdvalid),    136'(0));
`else
        checkOutput("toErrTied", 136'(bus.ebiuif_snp_timeout_err), 136'(0));
`endif

        // Reset while a request is pending discards it.
        $display("[TB] reset mid-operation");
        applyStimulus(40'h06_0000_00C0, 5'd8, 3'd0, 4'h1);
        n = 0;
        @(negedge clk);
        while (!bus.ebiuif_snp_req_vld && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus.ebiuif_snp_req_vld) reportTimeout("rstReqWait");
        @(posedge clk); #1;
        cpurst_b = 1'b0;
        @(negedge clk);
        checkOutput("midRstReqVld",  136'(bus.ebiuif_snp_req_vld),     136'(0));
        checkOutput("midRstAcGrant", 136'(bus.ebiuif_ebiu_ac_grant),   136'(0));
        checkOutput("midRstToErr",   136'(bus.ebiuif_snp_timeout_err), 136'(0));
        reqQ.delete();
        @(posedge clk); #1;
        cpurst_b = 1'b1;
        repeat (4) @(negedge clk);
        checkOutput("postRstFlushed", 136'(bus.ebiuif_snp_req_vld), 136'(0));

        checkOutput("reqQDrained", 136'(reqQ.size()), 136'(0));
        checkOutput("crQDrained",  136'(crQ.size()),  136'(0));
        checkOutput("cdQDrained",  136'(cdQ.size()),  136'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
